// File: rtl/rat_intr_pkg.sv
// Shared types and register offsets for the RAT interrupt controller.
package rat_intr_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } intr_state_t;

  localparam logic [1:0] OFS_MASK  = 2'd0;
  localparam logic [1:0] OFS_PEND  = 2'd1;
  localparam logic [1:0] OFS_CLAIM = 2'd2;
  localparam logic [1:0] OFS_EOI   = 2'd3;

  localparam int VEC_VALID_BIT = 7;

endpackage

// File: rtl/rat_intr_ctrl_prio_enc.sv
// Priority search over eligible sources starting at index `start`, wrapping modulo N_SRC.
module intr_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [2:0]       start,
  output logic [2:0]       idx,
  output logic             any
);

  always_comb begin
    idx = 3'd0;
    any = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      int j;
      j = (int'(start) + k) % N_SRC;
      if (!any && eligible[j]) begin
        any = 1'b1;
        idx = 3'(j);
      end
    end
  end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Edge-capturing interrupt controller for the RAT MCU with claim/EOI handshake.
// Define RAT_INTR_RR_EN for round-robin priority; default is fixed priority (index 0 highest).
//
// state   | meaning
// IDLE    | INTR reflects any eligible source; a CLAIM write latches the vector
// SERVICE | ISR running; INTR held low, CLAIM ignored, EOI returns to IDLE
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int         N_SRC     = 8,
  parameter logic [7:0] BASE_PORT = 8'hE0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic             INTR,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT
);

  intr_state_t      state_q, state_d;
  logic [N_SRC-1:0] irq_q, irq_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic             vec_valid_q, vec_valid_d;
  logic [2:0]       vec_idx_q, vec_idx_d;

  logic [N_SRC-1:0] eligible, rise, clr;
  logic [7:0]       ofs;
  logic             wr_mask, wr_pend, wr_claim, wr_eoi;
  logic [2:0]       enc_idx, enc_start;
  logic             enc_any;

  assign ofs      = PORT_ID - BASE_PORT;
  assign RD_HIT   = (ofs[7:2] == 6'd0);
  assign wr_mask  = IO_STRB && RD_HIT && (ofs[1:0] == OFS_MASK);
  assign wr_pend  = IO_STRB && RD_HIT && (ofs[1:0] == OFS_PEND);
  assign wr_claim = IO_STRB && RD_HIT && (ofs[1:0] == OFS_CLAIM);
  assign wr_eoi   = IO_STRB && RD_HIT && (ofs[1:0] == OFS_EOI);

  assign eligible = pend_q & mask_q;
  assign rise     = IRQ & ~irq_q;
  assign INTR     = (state_q == IDLE) && (|eligible);

`ifdef RAT_INTR_RR_EN
  logic [2:0] rr_q, rr_d;
  assign enc_start = rr_q;
`else
  assign enc_start = 3'd0;
`endif

  intr_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .eligible (eligible),
    .start    (enc_start),
    .idx      (enc_idx),
    .any      (enc_any)
  );

  always_comb begin
    state_d     = state_q;
    irq_d       = IRQ;
    mask_d      = mask_q;
    vec_valid_d = vec_valid_q;
    vec_idx_d   = vec_idx_q;
    clr         = '0;
`ifdef RAT_INTR_RR_EN
    rr_d        = rr_q;
`endif
    if (wr_mask) mask_d = OUT_PORT[N_SRC-1:0];
    if (wr_pend) clr = OUT_PORT[N_SRC-1:0];
    case (state_q)
      IDLE: begin
        if (wr_claim) begin
          if (enc_any) begin
            vec_valid_d  = 1'b1;
            vec_idx_d    = enc_idx;
            clr[enc_idx] = 1'b1;
            state_d      = SERVICE;
`ifdef RAT_INTR_RR_EN
            rr_d = (int'(enc_idx) == N_SRC - 1) ? 3'd0 : enc_idx + 3'd1;
`endif
          end else begin
            vec_valid_d = 1'b0;
            vec_idx_d   = 3'd0;
          end
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          vec_valid_d = 1'b0;
          vec_idx_d   = 3'd0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a new edge on the same cycle as a clear must survive
    pend_d = (pend_q & ~clr) | rise;
  end

  always_comb begin
    RD_DATA = 8'h00;
    if (RD_HIT) begin
      case (ofs[1:0])
        OFS_MASK:  RD_DATA[N_SRC-1:0] = mask_q;
        OFS_PEND:  RD_DATA[N_SRC-1:0] = pend_q;
        OFS_CLAIM: begin
          RD_DATA[VEC_VALID_BIT] = vec_valid_q;
          RD_DATA[2:0]           = vec_idx_q;
        end
        default:   RD_DATA = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      irq_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      vec_valid_q <= 1'b0;
      vec_idx_q   <= 3'd0;
`ifdef RAT_INTR_RR_EN
      rr_q        <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      vec_valid_q <= vec_valid_d;
      vec_idx_q   <= vec_idx_d;
`ifdef RAT_INTR_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Scoreboard bench for rat_intr_ctrl: expectations are queued with the stimulus and popped at observation.
module tb_rat_intr_ctrl;

  localparam logic [7:0] BASE = 8'hE0;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] irq      = 8'h00;
  logic [7:0] port_id  = 8'h00;
  logic [7:0] out_port = 8'h00;
  logic       io_strb  = 1'b0;
  logic       intr;
  logic [7:0] rd_data;
  logic       rd_hit;

  int n_chk  = 0;
  int n_pass = 0;

  string      q_tag[$];
  logic [7:0] q_exp[$];

  always #5 clk = ~clk;

  rat_intr_ctrl #(.N_SRC(8), .BASE_PORT(BASE)) dut (
    .CLK      (clk),
    .RESET    (reset),
    .IRQ      (irq),
    .PORT_ID  (port_id),
    .OUT_PORT (out_port),
    .IO_STRB  (io_strb),
    .INTR     (intr),
    .RD_DATA  (rd_data),
    .RD_HIT   (rd_hit)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
  endtask

  task automatic sb_push(input string tag, input logic [7:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask

  task automatic sb_check(input logic [7:0] obs);
    if (q_exp.size() == 0) begin
      n_chk++;
      $display("FAIL sb_underflow: got %02h expected nothing queued", obs);
    end else begin
      string      t;
      logic [7:0] e;
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [1:0] ofs, input logic [7:0] d);
    port_id  = BASE + {6'b0, ofs};
    out_port = d;
    io_strb  = 1'b1;
    tick();
    io_strb  = 1'b0;
  endtask

  task automatic obs_rd(input logic [1:0] ofs);
    port_id = BASE + {6'b0, ofs};
    #1;
    sb_check(rd_data);
  endtask

  task automatic obs_intr();
    sb_check({7'b0, intr});
  endtask

  task automatic pulse(input logic [7:0] bits);
    irq = bits;
    tick();
    irq = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_v;
    tick(); tick();
    reset = 1'b0;

    sb_push("rst_intr", 8'h00); obs_intr();
    sb_push("rst_mask", 8'h00); obs_rd(2'd0);
    sb_push("rst_pend", 8'h00); obs_rd(2'd1);
    sb_push("rst_vec", 8'h00);  obs_rd(2'd2);
    sb_push("hit_top", 8'h01);  port_id = BASE + 8'd3; #1; sb_check({7'b0, rd_hit});
    sb_push("hit_miss", 8'h00); port_id = BASE + 8'd4; #1; sb_check({7'b0, rd_hit});
    sb_push("miss_data", 8'h00); port_id = 8'h10; #1; sb_check(rd_data);

    // single source, claim, EOI
    io_wr(2'd0, 8'h05);
    sb_push("t1_intr", 8'h01); pulse(8'h04); obs_intr();
    sb_push("t1_vec", 8'h82); sb_push("t1_intr_svc", 8'h00);
    io_wr(2'd2, 8'h00); obs_rd(2'd2); obs_intr();
    sb_push("t1_intr_eoi", 8'h00); sb_push("t1_vec_eoi", 8'h00);
    io_wr(2'd3, 8'h00); obs_intr(); obs_rd(2'd2);

    // simultaneous rises: lower index first
    io_wr(2'd0, 8'hFF);
    sb_push("t2_intr", 8'h01); pulse(8'h48); obs_intr();
    sb_push("t2_vec1", 8'h83); io_wr(2'd2, 8'h00); obs_rd(2'd2);
    sb_push("t2_intr_eoi", 8'h01); io_wr(2'd3, 8'h00); obs_intr();
    sb_push("t2_vec2", 8'h86); io_wr(2'd2, 8'h00); obs_rd(2'd2);
    sb_push("t2_intr_end", 8'h00); io_wr(2'd3, 8'h00); obs_intr();

    // masked source stays pending; W1C
    io_wr(2'd0, 8'h00);
    sb_push("t3_pend", 8'h02); sb_push("t3_intr_masked", 8'h00);
    pulse(8'h02); obs_rd(2'd1); obs_intr();
    sb_push("t3_intr_unmask", 8'h01); io_wr(2'd0, 8'h02); obs_intr();
    sb_push("t3_pend_w1c", 8'h00); sb_push("t3_intr_w1c", 8'h00);
    io_wr(2'd1, 8'h02); obs_rd(2'd1); obs_intr();

    // no re-entry while in service
    io_wr(2'd0, 8'hFF);
    sb_push("t4_vec", 8'h82); pulse(8'h04); io_wr(2'd2, 8'h00); obs_rd(2'd2);
    sb_push("t4_intr_svc", 8'h00); pulse(8'h01); obs_intr();
    sb_push("t4_vec_reclaim", 8'h82); sb_push("t4_intr_reclaim", 8'h00);
    io_wr(2'd2, 8'h00); obs_rd(2'd2); obs_intr();
    sb_push("t4_intr_eoi", 8'h01); io_wr(2'd3, 8'h00); obs_intr();
    sb_push("t4_vec0", 8'h80); io_wr(2'd2, 8'h00); obs_rd(2'd2);
    sb_push("t4_intr_end", 8'h00); io_wr(2'd3, 8'h00); obs_intr();

    // held level sets pending once; set beats same-edge clear
    irq = 8'h10;
    sb_push("t5_pend_set", 8'h10); tick(); obs_rd(2'd1);
    repeat (3) tick();
    sb_push("t5_pend_clr", 8'h00); io_wr(2'd1, 8'h10); obs_rd(2'd1);
    repeat (4) tick();
    sb_push("t5_pend_held", 8'h00); obs_rd(2'd1);
    irq = 8'h00; tick();
    irq = 8'h10;
    sb_push("t5_set_wins", 8'h10); io_wr(2'd1, 8'h10); obs_rd(2'd1);
    irq = 8'h00;
    sb_push("t5_pend_flush", 8'h00); io_wr(2'd1, 8'hFF); obs_rd(2'd1);

    // reset while in service
    sb_push("t6_vec", 8'h81); pulse(8'h0A); io_wr(2'd2, 8'h00); obs_rd(2'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    sb_push("t6_intr", 8'h00); sb_push("t6_mask", 8'h00);
    sb_push("t6_pend", 8'h00); sb_push("t6_vec_rst", 8'h00);
    obs_intr(); obs_rd(2'd0); obs_rd(2'd1); obs_rd(2'd2);
    io_wr(2'd0, 8'hFF);
    sb_push("t6_idle_intr", 8'h01); pulse(8'h08); obs_intr();
    sb_push("t6_flush_intr", 8'h00); io_wr(2'd1, 8'hFF); obs_intr();

    // priority policy with two re-pending sources
    io_wr(2'd0, 8'h21);
    for (int i = 0; i < 4; i++) begin
`ifdef RAT_INTR_RR_EN
      exp_v = (i % 2 == 1) ? 8'h85 : 8'h80;
`else
      exp_v = 8'h80;
`endif
      sb_push($sformatf("t7_claim%0d", i), exp_v);
      pulse(8'h21);
      tick();
      io_wr(2'd2, 8'h00);
      obs_rd(2'd2);
      io_wr(2'd3, 8'h00);
    end

    check("sb_leftover", 8'(q_exp.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rat_intr_ctrl.md
# rat_intr_ctrl

Memory-free interrupt controller that sits between up to eight peripheral interrupt sources and the single `INTR` input of the RAT MCU. It captures rising edges into pending bits, applies a mask, and picks one source by priority. It drives `INTR` and hands the selected vector to the interrupt service routine (ISR) through the MCU's port-mapped I/O (`PORT_ID`, `OUT_PORT`, `IO_STRB`, `IN_PORT`). A claim/end-of-interrupt (EOI) handshake prevents re-entry while a source is in service.

## Interface
- `N_SRC`, 8, number of interrupt sources (1..8); unused register bits read 0.
- `BASE_PORT`, 8'hE0, first of four consecutive port IDs used by the block.

- `CLK` in 1: system clock.
- `RESET` in 1: reset. Synchronous, active-high.
- `IRQ` in N_SRC: source requests, synchronous to `CLK`, rising-edge significant.
- `PORT_ID` in 8: MCU port address.
- `OUT_PORT` in 8: MCU write data.
- `IO_STRB` in 1: MCU write strobe, one cycle per OUT instruction.
- `INTR` out 1: interrupt request to the MCU.
- `RD_DATA` out 8: read data for `IN_PORT` mux; combinational from `PORT_ID` and registers.
- `RD_HIT` out 1: `PORT_ID` lies in `BASE_PORT..BASE_PORT+3`; the top level selects `RD_DATA` onto `IN_PORT` when this is high.

## Operation
- Registers, addressed at offset from `BASE_PORT`:
  - **+0 MASK** (R/W): a 1 enables that source.
  - **+1 PEND** (R; write-1-to-clear).
  - **+2 CLAIM**: a write claims the interrupt. Reads return VECTOR = {valid, 4'b0, idx[2:0]}.
  - **+3 EOI** (W).
- Writes take effect on a `CLK` edge with `IO_STRB`=1 and a matching `PORT_ID`.
- Edge capture:
  - `irq_q` is registered `IRQ`.
  - `pend[i]` is set on an edge where `IRQ[i]`=1 and `irq_q[i]`=0.
  - A set and a clear of the same bit in the same cycle (W1C or claim): the set wins.
- `eligible = pend & MASK`.
- State machine `IDLE`/`SERVICE`:
  - **IDLE**: `INTR` = |eligible.
    - A CLAIM write with eligible≠0 latches VECTOR={1,idx}, clears `pend[idx]`, and goes to SERVICE.
    - A CLAIM write with eligible=0 sets VECTOR={0,0} and stays in IDLE.
  - **SERVICE**: `INTR`=0, regardless of pending. CLAIM writes are ignored. An EOI write clears VECTOR.valid and returns to IDLE.
  - An EOI write in IDLE is ignored.
- Priority: fixed, lowest index wins, unless the round-robin option is enabled (see Configuration).
- A MASK write takes effect on the next cycle; `INTR` follows at once. A masked source stays pending.
- Reset values:
  - MASK=0, PEND=0, `irq_q`=0, VECTOR=0, state IDLE, RR pointer=0.
  - `INTR`=0. `RD_HIT` and `RD_DATA` depend only on `PORT_ID` and these registers.
  - Reset during SERVICE returns to IDLE and discards all pending bits.

## Timing
- Edge latency: `IRQ[i]` sampled 1 at edge k and 0 at edge k-1 gives `pend[i]`=1 and `INTR`=1 (if enabled, IDLE) after edge k. That is one cycle of latency, and `INTR` is driven from registers only.
- Claim: on the edge with the CLAIM write, VECTOR and state update, and `INTR` is 0 from the next cycle.
- A CLAIM read (IN instruction) in the following instruction sees the new VECTOR.
- EOI: if eligible≠0, `INTR` is high again in the cycle after the EOI edge.
- `RD_DATA`/`RD_HIT`: zero-latency combinational read; stable for the whole IN instruction.

## Configuration
- `RAT_INTR_RR_EN` defined: round-robin priority.
  - A pointer `rr` (3 bits) marks the highest-priority index. The search goes rr, rr+1, … modulo N_SRC.
  - A successful claim sets rr to idx+1 (wrapping to 0 at N_SRC).
- `RAT_INTR_RR_EN` undefined: fixed priority with index 0 highest. The `rr` register is not built.

## Structure
- Package `rat_intr_pkg`:
  - state enum `intr_state_t` {IDLE, SERVICE};
  - localparams `OFS_MASK`=0, `OFS_PEND`=1, `OFS_CLAIM`=2, `OFS_EOI`=3;
  - `VEC_VALID_BIT`=7.
- Sub-module `intr_prio_enc`: combinational, inputs eligible[N_SRC] and start[2:0], outputs idx[2:0] and any. With fixed priority, start is tied to 0.

## Test plan
- Reset, MASK=8'h05, pulse `IRQ[2]` → `INTR`=1 one cycle later. CLAIM write, then read +2 → 8'h82, `INTR`=0. EOI → `INTR`=0, VECTOR reads 8'h00.
- MASK=8'hFF, `IRQ[6]` and `IRQ[3]` rise in the same cycle. First claim returns 8'h83, EOI raises `INTR` again the next cycle, second claim returns 8'h86.
- MASK=0, pulse `IRQ[1]` → PEND reads 8'h02 and `INTR`=0. Writing MASK=8'h02 gives `INTR`=1. W1C of 8'h02 to +1 gives PEND=0 and `INTR`=0.
- In SERVICE, pulse `IRQ[0]` and issue a second CLAIM → VECTOR unchanged and `INTR` stays 0. After EOI, `INTR`=1.
- Hold `IRQ[4]` high for 10 cycles → exactly one pending set. A W1C on the same edge as a new `IRQ[4]` rise leaves PEND[4]=1.
- With `RAT_INTR_RR_EN`: keep sources 0 and 5 re-pending → claims alternate 0, 5, 0, 5. Without the macro → always 0.
- Also required: `RESET` asserted in SERVICE → state IDLE, all registers 0 on the next cycle.
